// File: rtl/gpio_pin_ctrl_pkg.sv
// gpio_defs: sizing and polarity constants shared by the GPIO register file and pin controller
package gpio_defs;
    localparam int GPIO_WIDTH         = 16;
    localparam int GPIO_SYNC_STAGES   = 2;
    localparam int GPIO_FILTER_CYCLES = 4;
    localparam bit TRISTATE_INPUT     = 1'b1;
    localparam bit MASK_DISABLED      = 1'b1;
    function automatic int cnt_width(int f);
        return (f > 1) ? $clog2(f) : 1;
    endfunction
endpackage

// File: rtl/gpio_pin_filter.sv
// gpio_pin_filter: single-pin synchroniser, stability filter and pin-state flop with edge event
module gpio_pin_filter
    import gpio_defs::*;
#(
    parameter int SYNC_STAGES   = GPIO_SYNC_STAGES,
    parameter int FILTER_CYCLES = GPIO_FILTER_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    output logic state,
    output logic edge_evt
);
    localparam int CW = cnt_width(FILTER_CYCLES);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    assign s = sync[SYNC_STAGES-1];
    // the event is the toggle decision itself, so pending sets on the same edge as pinstate
    assign edge_evt = (s != state) && (cnt == CW'(FILTER_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            state <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin_in};
            if (s == state)
                cnt <= '0;
            else if (edge_evt) begin
                state <= s;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: pad output/enable registers, filtered pin readback, sticky edge pending and maskable irq
module gpio_pin_ctrl
    import gpio_defs::*;
#(
    parameter int WIDTH         = GPIO_WIDTH,
    parameter int SYNC_STAGES   = GPIO_SYNC_STAGES,
    parameter int FILTER_CYCLES = GPIO_FILTER_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rf_gpio_datareg,
    input  logic [WIDTH-1:0] rf_gpio_tristate,
    input  logic [WIDTH-1:0] rf_gpio_interrupt_mask,
    input  logic [WIDTH-1:0] rf_gpio_int_clear,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic [WIDTH-1:0] ro_gpio_pinstate,
    output logic [WIDTH-1:0] ro_gpio_int_pending,
    output logic             gpio_irq
);
    logic [WIDTH-1:0] evt;
    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        gpio_pin_filter #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_filter (
            .clk     (clk),
            .reset   (reset),
            .pin_in  (gpio_in[g]),
            .state   (ro_gpio_pinstate[g]),
            .edge_evt(evt[g])
        );
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out            <= '0;
            gpio_oe             <= '0;
            ro_gpio_int_pending <= '0;
            gpio_irq            <= 1'b0;
        end else begin
            gpio_out            <= rf_gpio_datareg;
            gpio_oe             <= rf_gpio_tristate ^ {WIDTH{TRISTATE_INPUT}};
            // set wins over clear so an event coinciding with a clear is kept
            ro_gpio_int_pending <= (ro_gpio_int_pending & ~rf_gpio_int_clear) | evt;
            gpio_irq            <= |(ro_gpio_int_pending & (rf_gpio_interrupt_mask ^ {WIDTH{MASK_DISABLED}}));
        end
    end
endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// tb_gpio_pin_ctrl: directed and random checks of gpio_pin_ctrl against a sample-history reference model
module tb_gpio_pin_ctrl;
    localparam int W  = 16;
    localparam int SS = 2;
    localparam int FC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] datareg = '0, tristate = '1, mask = '1, clr = '0, gpio_in = '0;
    logic [W-1:0] gpio_out, gpio_oe, pinstate, pending;
    logic         irq;

    int total = 0;
    int bad = 0;

    logic [W-1:0] m_out = '0, m_oe = '0, m_pin = '0, m_pend = '0;
    logic         m_irq = 1'b0;
    logic [W-1:0] hist[$];

    gpio_pin_ctrl dut (
        .clk                   (clk),
        .reset                 (reset),
        .rf_gpio_datareg       (datareg),
        .rf_gpio_tristate      (tristate),
        .rf_gpio_interrupt_mask(mask),
        .rf_gpio_int_clear     (clr),
        .gpio_in               (gpio_in),
        .gpio_out              (gpio_out),
        .gpio_oe               (gpio_oe),
        .ro_gpio_pinstate      (pinstate),
        .ro_gpio_int_pending   (pending),
        .gpio_irq              (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pin toggles when the last FC synchronised samples all differ from its current filtered level.
    task automatic step();
        logic [W-1:0] ev;
        bit           diff;
        ev = '0;
        for (int i = 0; i < W; i++) begin
            diff = 1'b1;
            for (int j = 0; j < FC; j++)
                if (hist[hist.size() - SS - j][i] == m_pin[i]) diff = 1'b0;
            ev[i] = diff;
        end
        if (reset) begin
            {m_out, m_oe, m_pin, m_pend} = '0;
            m_irq = 1'b0;
            foreach (hist[k]) hist[k] = '0;
            hist.push_back('0);
        end else begin
            m_irq  = |(m_pend & ~mask);
            m_pend = (m_pend & ~clr) | ev;
            m_pin  = m_pin ^ ev;
            m_out  = datareg;
            m_oe   = ~tristate;
            hist.push_back(gpio_in);
        end
        while (hist.size() > 8) void'(hist.pop_front());
        @(posedge clk);
        #1;
        chk("gpio_out", gpio_out, m_out);
        chk("gpio_oe", gpio_oe, m_oe);
        chk("pinstate", pinstate, m_pin);
        chk("pending", pending, m_pend);
        chk("irq", {15'd0, irq}, {15'd0, m_irq});
    endtask

    initial begin
        repeat (8) hist.push_back('0);
        // reset with all pads high, then six-edge latency
        gpio_in = 16'hFFFF;
        repeat (2) step();
        chk("rst_pinstate", pinstate, 16'h0000);
        reset = 1'b0;
        repeat (5) step();
        chk("lat_edge5", pinstate, 16'h0000);
        step();
        chk("lat_edge6", pinstate, 16'hFFFF);
        chk("lat_pending", pending, 16'hFFFF);
        // output path
        datareg = 16'hA5A5;
        tristate = 16'h00FF;
        step();
        chk("out_path", gpio_out, 16'hA5A5);
        chk("oe_path", gpio_oe, 16'hFF00);
        // glitch rejection on pin 3
        gpio_in = '0;
        repeat (8) step();
        clr = 16'hFFFF;
        step();
        clr = '0;
        gpio_in = 16'h0008;
        repeat (3) step();
        gpio_in = '0;
        repeat (8) step();
        chk("glitch3_pin", {15'd0, pinstate[3]}, 16'd0);
        chk("glitch3_pend", {15'd0, pending[3]}, 16'd0);
        gpio_in = 16'h0008;
        repeat (4) step();
        gpio_in = '0;
        step();
        chk("pulse4_e5", {15'd0, pinstate[3]}, 16'd0);
        step();
        chk("pulse4_e6", {15'd0, pinstate[3]}, 16'd1);
        repeat (3) step();
        chk("pulse4_e9", {15'd0, pinstate[3]}, 16'd1);
        step();
        chk("pulse4_e10", {15'd0, pinstate[3]}, 16'd0);
        chk("pulse4_pend", {15'd0, pending[3]}, 16'd1);
        // masking on pin 5
        mask = 16'hFFFF;
        gpio_in = 16'h0020;
        repeat (8) step();
        chk("mask_pend5", {15'd0, pending[5]}, 16'd1);
        chk("mask_irq0", {15'd0, irq}, 16'd0);
        mask = 16'hFFDF;
        step();
        chk("unmask_irq", {15'd0, irq}, 16'd1);
        clr = 16'h0020;
        step();
        clr = '0;
        chk("clr_pend5", {15'd0, pending[5]}, 16'd0);
        step();
        chk("clr_irq", {15'd0, irq}, 16'd0);
        // set/clear collision on pin 7
        gpio_in = 16'h00A0;
        repeat (5) step();
        clr = 16'h0080;
        step();
        clr = '0;
        chk("collide_pin7", {15'd0, pinstate[7]}, 16'd1);
        chk("collide_pend7", {15'd0, pending[7]}, 16'd1);
        // reset while pin 0 filter count is at 2
        gpio_in = 16'h00A1;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_pin0", {15'd0, pinstate[0]}, 16'd0);
        repeat (5) step();
        chk("midrst_e5", {15'd0, pinstate[0]}, 16'd0);
        step();
        chk("midrst_e6", {15'd0, pinstate[0]}, 16'd1);
        // random traffic
        for (int n = 0; n < 600; n++) begin
            gpio_in ^= W'($urandom & $urandom & $urandom);
            datareg = W'($urandom);
            tristate = W'($urandom);
            if ($urandom_range(0, 15) == 0) mask = W'($urandom);
            clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        clr = '0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpio_pin_ctrl.md
Name: gpio_pin_ctrl

Overview:
- Pin-side counterpart of the GPIO register file.
- Consumes the register file's rf_gpio_datareg, rf_gpio_tristate and rf_gpio_interrupt_mask outputs and drives the pad output and output-enable signals.
- Synchronises and glitch-filters pad inputs, then returns them to the register file as ro_gpio_pinstate.
- Detects edges on the filtered inputs, latches them into sticky pending bits, and raises a single maskable interrupt line.

Parameters:
- WIDTH, 16, number of GPIO pins.
- SYNC_STAGES, 2, synchroniser flops per pin (minimum 2).
- FILTER_CYCLES, 4, consecutive stable cycles required before the filtered state changes (minimum 1; 1 = no filtering).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rf_gpio_datareg  input  WIDTH  output drive values.
- rf_gpio_tristate  input  WIDTH  1 = pin is input (high-Z), 0 = pin driven.
- rf_gpio_interrupt_mask  input  WIDTH  1 = pin interrupt masked.
- rf_gpio_int_clear  input  WIDTH  one-cycle write-1-to-clear pulse for pending bits.
- gpio_in  input  WIDTH  asynchronous pad input levels.
- gpio_out  output  WIDTH  pad output values.
- gpio_oe  output  WIDTH  pad output enables, 1 = drive.
- ro_gpio_pinstate  output  WIDTH  filtered pin levels.
- ro_gpio_int_pending  output  WIDTH  sticky edge-detected bits.
- gpio_irq  output  1  interrupt request.

Behaviour:
- Reset (synchronous, active-high, clk only) clears to 0: gpio_out, gpio_oe (all pins input), ro_gpio_pinstate, ro_gpio_int_pending, gpio_irq, all synchroniser flops, all filter counters.
- Reset asserted mid-operation takes effect at the next edge. A filter count in progress is discarded. No edge or pending bit is generated by the reset itself.
- Output path: gpio_out <= rf_gpio_datareg and gpio_oe <= ~rf_gpio_tristate, registered, 1-cycle latency.
- Input path, per pin:
  - gpio_in passes through a SYNC_STAGES flop chain to give s.
  - Filter counter cnt has width clog2(FILTER_CYCLES), minimum 1.
  - If s == pinstate: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: pinstate <= s, cnt <= 0.
  - Else: cnt <= cnt+1.
- Input latency: a pad change held stable appears on ro_gpio_pinstate at rising edge number SYNC_STAGES+FILTER_CYCLES, counting the first edge that samples the new level as edge 1. Default is edge 6.
- Glitch rejection: a level at s lasting fewer than FILTER_CYCLES cycles never reaches pinstate.
- Pinstate reports the pad level regardless of direction, so driven pins read back their own output.
- Edge detect: a pin's event fires on the same edge its pinstate toggles, for both rising and falling edges.
- Pending update per bit: pending <= (pending & ~clear) | event.
  - A simultaneous set and clear leaves the bit set, so no event is lost.
  - Pending latches whether or not the pin is masked.
- gpio_irq <= |(pending & ~rf_gpio_interrupt_mask). It is registered, so it asserts 1 edge after pending sets or a mask bit drops. It deasserts 1 edge after the last unmasked pending bit clears or gets masked.
- FILTER_CYCLES=1: pinstate follows s with 1 edge of delay, giving latency SYNC_STAGES+1.

Decomposition:
- Shared package gpio_defs:
  - GPIO_WIDTH = 16
  - GPIO_SYNC_STAGES = 2
  - GPIO_FILTER_CYCLES = 4
  - the polarity constants TRISTATE_INPUT = 1 and MASK_DISABLED = 1, shared with the register file.
- One sub-module, gpio_pin_filter: a single-bit synchroniser, filter counter and pinstate flop with an edge-event output, instantiated WIDTH times by a generate loop.
- Output registers, pending logic and irq stay in the top level.

Test Plan:
- Reset check: hold reset 2 cycles with gpio_in = 16'hFFFF → all outputs 0. After release, ro_gpio_pinstate = 16'hFFFF exactly at edge 6, and pending = 16'hFFFF.
- Output path: rf_gpio_datareg = 16'hA5A5, rf_gpio_tristate = 16'h00FF → gpio_out = 16'hA5A5 and gpio_oe = 16'hFF00 one edge later.
- Glitch rejection: a gpio_in[3] pulse of 3 cycles → pinstate[3] and pending[3] stay 0. A 4-cycle pulse → pinstate[3] rises at edge 6, then falls 4 cycles after it rose, and pending[3] = 1.
- Masking: pending[5] = 1 with mask[5] = 1 → gpio_irq = 0. Drop mask[5] → gpio_irq = 1 the next edge. Pulse rf_gpio_int_clear = 16'h0020 → pending[5] = 0 and gpio_irq = 0 one edge later.
- Set/clear collision: clear[7] pulsed on the same edge pin 7's event fires → pending[7] remains 1.
- Reset mid-filter: assert reset while cnt = 2 on pin 0 → cnt = 0 and pinstate[0] = 0. With the new level still held, pinstate[0] updates only after the full 6 edges restart post-reset.
